// File: rtl/ysyx_22050550_clint_axi_pkg.sv
// Shared constants for the CLINT AXI4-Lite bridge: FSM state codes,
// response codes, default CLINT register addresses and the address check.
package ysyx_22050550_clint_axi_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_W_WAIT_AW = 3'd1;
    localparam logic [2:0] ST_W_WAIT_W  = 3'd2;
    localparam logic [2:0] ST_W_EXEC    = 3'd3;
    localparam logic [2:0] ST_W_RESP    = 3'd4;
    localparam logic [2:0] ST_R_RESP    = 3'd5;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    localparam logic [63:0] DEF_MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] DEF_MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

    // Only the two 8-byte aligned timer registers are reachable.
    function automatic logic addr_legal(input logic [63:0] addr,
                                        input logic [63:0] mtime_addr,
                                        input logic [63:0] mtimecmp_addr);
        return ((addr == mtime_addr) || (addr == mtimecmp_addr)) && (addr[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/ysyx_22050550_strb_merge.sv
// Byte merge of write data into the current CLINT word. Honours wstrb only
// when YSYX_22050550_CLINT_WSTRB_EN is defined; otherwise passes wdata through.
module ysyx_22050550_strb_merge (
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    input  logic [7:0]  strb,
    output logic [63:0] merged
);

`ifdef YSYX_22050550_CLINT_WSTRB_EN
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            assign merged[gi*8 +: 8] = strb[gi] ? wdata[gi*8 +: 8] : rdata[gi*8 +: 8];
        end
    endgenerate
`else
    logic unused_inputs;
    assign unused_inputs = ^{rdata, strb};
    assign merged        = wdata;
`endif

endmodule

// File: rtl/ysyx_22050550_clint_axi.sv
// AXI4-Lite slave front-end for the CLINT timer registers, one transaction at a time.
// Optional byte-strobe read-modify-write is enabled by YSYX_22050550_CLINT_WSTRB_EN.
module ysyx_22050550_clint_axi
    import ysyx_22050550_clint_axi_pkg::*;
#(
    parameter logic [63:0] MTIME_ADDR    = DEF_MTIME_ADDR,
    parameter logic [63:0] MTIMECMP_ADDR = DEF_MTIMECMP_ADDR
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        awvalid,
    output logic        awready,
    input  logic [63:0] awaddr,

    input  logic        wvalid,
    output logic        wready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,

    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,

    input  logic        arvalid,
    output logic        arready,
    input  logic [63:0] araddr,

    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,

    output logic        clint_ren,
    output logic [63:0] clint_raddr,
    output logic        clint_wen,
    output logic [63:0] clint_waddr,
    output logic [63:0] clint_wdata,
    input  logic [63:0] clint_rdata
);

    logic [2:0]  state_reg, state_next;
    logic [63:0] addr_reg, addr_next;
    logic [63:0] data_reg, data_next;
    logic [7:0]  strb_reg, strb_next;
    logic [63:0] rdata_reg, rdata_next;
    resp_t       bresp_reg, bresp_next;
    resp_t       rresp_reg, rresp_next;

    logic        idle;
    logic        exec;
    logic        ar_fire;
    logic        exec_legal;
    logic        rd_legal;
    logic [63:0] merged;

    // Ready/strobe outputs are qualified by reset so nothing leaks while it is held.
    assign idle       = reset && (state_reg == ST_IDLE);
    assign exec       = reset && (state_reg == ST_W_EXEC);
    assign awready    = idle || (reset && (state_reg == ST_W_WAIT_AW));
    assign wready     = idle || (reset && (state_reg == ST_W_WAIT_W));
    assign arready    = idle && !awvalid && !wvalid;
    assign ar_fire    = arready && arvalid;

    assign exec_legal = addr_legal(addr_reg, MTIME_ADDR, MTIMECMP_ADDR);
    assign rd_legal   = addr_legal(araddr, MTIME_ADDR, MTIMECMP_ADDR);

    assign bvalid     = (state_reg == ST_W_RESP);
    assign rvalid     = (state_reg == ST_R_RESP);
    assign bresp      = bresp_reg;
    assign rresp      = rresp_reg;
    assign rdata      = rdata_reg;

    assign clint_ren   = ar_fire || exec;
    assign clint_raddr = (state_reg == ST_W_EXEC) ? addr_reg : araddr;
    assign clint_wen   = exec && exec_legal;
    assign clint_waddr = addr_reg;
    assign clint_wdata = merged;

    ysyx_22050550_strb_merge u_strb_merge (
        .wdata  (data_reg),
        .rdata  (clint_rdata),
        .strb   (strb_reg),
        .merged (merged)
    );

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        strb_next  = strb_reg;
        rdata_next = rdata_reg;
        bresp_next = bresp_reg;
        rresp_next = rresp_reg;
        case (state_reg)
            ST_IDLE: begin
                if (awvalid && wvalid) begin
                    addr_next  = awaddr;
                    data_next  = wdata;
                    strb_next  = wstrb;
                    state_next = ST_W_EXEC;
                end else if (awvalid) begin
                    addr_next  = awaddr;
                    state_next = ST_W_WAIT_W;
                end else if (wvalid) begin
                    data_next  = wdata;
                    strb_next  = wstrb;
                    state_next = ST_W_WAIT_AW;
                end else if (arvalid) begin
                    rdata_next = rd_legal ? clint_rdata : 64'd0;
                    rresp_next = rd_legal ? RESP_OKAY : RESP_SLVERR;
                    state_next = ST_R_RESP;
                end
            end
            ST_W_WAIT_AW: begin
                if (awvalid) begin
                    addr_next  = awaddr;
                    state_next = ST_W_EXEC;
                end
            end
            ST_W_WAIT_W: begin
                if (wvalid) begin
                    data_next  = wdata;
                    strb_next  = wstrb;
                    state_next = ST_W_EXEC;
                end
            end
            ST_W_EXEC: begin
                bresp_next = exec_legal ? RESP_OKAY : RESP_SLVERR;
                state_next = ST_W_RESP;
            end
            ST_W_RESP: begin
                if (bready) state_next = ST_IDLE;
            end
            ST_R_RESP: begin
                if (rready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            addr_reg  <= 64'd0;
            data_reg  <= 64'd0;
            strb_reg  <= 8'd0;
            rdata_reg <= 64'd0;
            bresp_reg <= RESP_OKAY;
            rresp_reg <= RESP_OKAY;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            strb_reg  <= strb_next;
            rdata_reg <= rdata_next;
            bresp_reg <= bresp_next;
            rresp_reg <= rresp_next;
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_clint_axi.sv
// Bench for the CLINT AXI bridge: behavioural timer model on the CLINT side,
// directed scenarios followed by random writes checked against a register model.
module tb_ysyx_22050550_clint_axi;

    localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [63:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [7:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;
    logic        clint_ren, clint_wen;
    logic [63:0] clint_raddr, clint_waddr, clint_wdata, clint_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ysyx_22050550_clint_axi dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .clint_ren(clint_ren), .clint_raddr(clint_raddr),
        .clint_wen(clint_wen), .clint_waddr(clint_waddr),
        .clint_wdata(clint_wdata), .clint_rdata(clint_rdata)
    );

    // Timer model: mtime free-runs, a write reloads it; mtimecmp is a plain register.
    logic [63:0] mtime_q = '0, mtimecmp_q = '0;
    int edge_cnt = 0, wen_edge = 0, wen_cnt = 0;

    always @(posedge clock) begin
        edge_cnt <= edge_cnt + 1;
        if (clint_wen) begin
            wen_cnt  <= wen_cnt + 1;
            wen_edge <= edge_cnt + 1;
        end
        if (clint_wen && clint_waddr == A_CMP) mtimecmp_q <= clint_wdata;
        if (clint_wen && clint_waddr == A_MTIME) mtime_q <= clint_wdata;
        else mtime_q <= mtime_q + 64'd1;
    end

    assign clint_rdata = !clint_ren ? 64'd0 :
                         (clint_raddr == A_MTIME) ? mtime_q :
                         (clint_raddr == A_CMP)   ? mtimecmp_q : 64'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge_model(input logic [63:0] old_v, input logic [63:0] new_v,
                                                input logic [7:0] strb);
        logic [63:0] mask;
        for (int i = 0; i < 8; i++) mask[i*8 +: 8] = {8{strb[i]}};
`ifndef YSYX_22050550_CLINT_WSTRB_EN
        mask = '1;
`endif
        return (new_v & mask) | (old_v & ~mask);
    endfunction

    function automatic logic [1:0] resp_model(input logic [63:0] addr);
        return ((addr == A_MTIME || addr == A_CMP) && addr[2:0] == 3'b000) ? 2'b00 : 2'b10;
    endfunction

    // lead > 0: W is presented lead cycles before AW; lead < 0: AW leads.
    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int lead, input int bhold,
                            output logic [1:0] resp, output logic wen_exec, output int lat);
        int  aw_start, w_start, cyc;
        bit  aw_done, w_done, aw_fire, w_fire;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_start);
            wvalid  = !w_done && (cyc >= w_start);
            #1;
            if (w_done && !aw_done) begin
                chk("wait_aw_wready", 64'(wready), 64'd0);
                chk("wait_aw_wen", 64'(clint_wen), 64'd0);
            end
            if (aw_done && !w_done) chk("wait_w_awready", 64'(awready), 64'd0);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clock); #1;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        chk("wr_accept", 64'(aw_done && w_done), 64'd1);
        wen_exec = clint_wen;
        lat = 1;
        while (!bvalid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        for (int i = 0; i < bhold; i++) begin
            @(posedge clock); #1;
            chk("wr_bvalid_hold", 64'(bvalid), 64'd1);
        end
        resp = bresp;
        bready = 1;
        @(posedge clock); #1;
        bready = 0;
        chk("wr_bvalid_drop", 64'(bvalid), 64'd0);
        chk("wr_idle_awready", 64'(awready), 64'd1);
        $display("write addr=%h data=%h strb=%h lead=%0d resp=%b lat=%0d", addr, data, strb, lead, resp, lat);
    endtask

    task automatic do_read(input logic [63:0] addr, input int rhold,
                           output logic [63:0] data, output logic [1:0] resp,
                           output int lat, output int acc_edge);
        bit          fire;
        int          cyc;
        logic [63:0] first;
        fire = 0; cyc = 0;
        araddr = addr; arvalid = 1;
        while (!fire && cyc < 40) begin
            #1;
            fire = arready;
            @(posedge clock); #1;
            cyc++;
        end
        arvalid = 0;
        acc_edge = edge_cnt;
        chk("rd_accept", 64'(fire), 64'd1);
        lat = 1;
        while (!rvalid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        first = rdata;
        for (int i = 0; i < rhold; i++) begin
            @(posedge clock); #1;
            chk("rd_hold_rvalid", 64'(rvalid), 64'd1);
            chk("rd_hold_rdata", rdata, first);
        end
        data = rdata; resp = rresp;
        rready = 1;
        @(posedge clock); #1;
        rready = 0;
        chk("rd_rvalid_drop", 64'(rvalid), 64'd0);
        $display("read  addr=%h data=%h resp=%b lat=%0d", addr, data, resp, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic        wen_e;
        logic [63:0] d, addr, data, exp_cmp;
        logic [7:0]  strb;
        int          lat, acc, w0, lead, kind;

        exp_cmp = '0;

        // Reset state, including a read request that must not reach the CLINT.
        @(posedge clock); #1;
        arvalid = 1; araddr = A_CMP;
        #1;
        chk("rst_clint_ren", 64'(clint_ren), 64'd0);
        chk("rst_clint_wen", 64'(clint_wen), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        arvalid = 0;
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        chk("idle_awready", 64'(awready), 64'd1);
        chk("idle_wready", 64'(wready), 64'd1);
        chk("idle_arready", 64'(arready), 64'd1);
        chk("idle_clint_ren", 64'(clint_ren), 64'd0);

        // AW+W together to mtimecmp.
        w0 = wen_cnt;
        do_write(A_CMP, 64'h1234, 8'hFF, 0, 0, resp, wen_e, lat);
        exp_cmp = merge_model(exp_cmp, 64'h1234, 8'hFF);
        chk("w1_wen_exec", 64'(wen_e), 64'd1);
        chk("w1_bvalid_lat", 64'(lat), 64'd2);
        chk("w1_bresp", 64'(resp), 64'd0);
        chk("w1_wen_count", 64'(wen_cnt - w0), 64'd1);
        do_read(A_CMP, 0, d, resp, lat, acc);
        chk("r1_rdata", d, 64'h1234);
        chk("r1_rresp", 64'(resp), 64'd0);
        chk("r1_rvalid_lat", 64'(lat), 64'd1);

        // W three cycles ahead of AW, reloading mtime.
        w0 = wen_cnt;
        do_write(A_MTIME, 64'h50, 8'hFF, 3, 1, resp, wen_e, lat);
        chk("w2_wen_count", 64'(wen_cnt - w0), 64'd1);
        chk("w2_bresp", 64'(resp), 64'd0);
        chk("w2_bvalid_lat", 64'(lat), 64'd2);
        do_read(A_MTIME, 0, d, resp, lat, acc);
        chk("r2_mtime", d, 64'h50 + 64'(acc - 1 - wen_edge));
        chk("r2_rresp", 64'(resp), 64'd0);

        // Read with rready held low for four cycles.
        do_read(A_CMP, 4, d, resp, lat, acc);
        chk("r3_rdata", d, exp_cmp);
        chk("r3_rresp", 64'(resp), 64'd0);

        // Illegal write and illegal read.
        w0 = wen_cnt;
        do_write(64'h0200_4004, 64'hDEAD, 8'hFF, -2, 2, resp, wen_e, lat);
        chk("w4_bresp", 64'(resp), 64'd2);
        chk("w4_wen_exec", 64'(wen_e), 64'd0);
        chk("w4_wen_count", 64'(wen_cnt - w0), 64'd0);
        do_read(64'h0200_0000, 1, d, resp, lat, acc);
        chk("r4_rresp", 64'(resp), 64'd2);
        chk("r4_rdata", d, 64'd0);

        // Partial-strobe write over a known mtimecmp.
        do_write(A_CMP, 64'hAABBCCDD_11223344, 8'hFF, -1, 0, resp, wen_e, lat);
        exp_cmp = merge_model(exp_cmp, 64'hAABBCCDD_11223344, 8'hFF);
        do_write(A_CMP, 64'hFF, 8'h01, 0, 0, resp, wen_e, lat);
        exp_cmp = merge_model(exp_cmp, 64'hFF, 8'h01);
        do_read(A_CMP, 0, d, resp, lat, acc);
`ifdef YSYX_22050550_CLINT_WSTRB_EN
        chk("r5_strb_merge", d, 64'hAABBCCDD_112233FF);
`else
        chk("r5_strb_ignored", d, 64'h0000_0000_0000_00FF);
`endif

        // Reset while in the execute cycle abandons the write.
        w0 = wen_cnt;
        awaddr = A_CMP; wdata = 64'h7777; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
        @(posedge clock); #1;
        awvalid = 0; wvalid = 0;
        reset = 0;
        #1;
        chk("rx_clint_wen", 64'(clint_wen), 64'd0);
        chk("rx_bvalid", 64'(bvalid), 64'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rx_wen_count", 64'(wen_cnt - w0), 64'd0);
        reset = 1;
        @(posedge clock); #1;
        chk("rx_awready", 64'(awready), 64'd1);
        chk("rx_arready", 64'(arready), 64'd1);
        chk("rx_bvalid_after", 64'(bvalid), 64'd0);
        do_read(A_CMP, 0, d, resp, lat, acc);
        chk("rx_cmp_kept", d, exp_cmp);

        // AW and AR together: write is served first, read only after bready.
        w0 = wen_cnt;
        awaddr = A_CMP; araddr = A_CMP; awvalid = 1; arvalid = 1;
        #1;
        chk("awar_arready", 64'(arready), 64'd0);
        chk("awar_awready", 64'(awready), 64'd1);
        @(posedge clock); #1;
        awvalid = 0; wdata = 64'h5A5A_0000_C3C3_0001; wstrb = 8'hFF; wvalid = 1;
        #1;
        chk("awar_arready_wait", 64'(arready), 64'd0);
        @(posedge clock); #1;
        wvalid = 0;
        @(posedge clock); #1;
        chk("awar_bvalid", 64'(bvalid), 64'd1);
        chk("awar_rvalid_early", 64'(rvalid), 64'd0);
        chk("awar_bresp", 64'(bresp), 64'd0);
        chk("awar_wen_count", 64'(wen_cnt - w0), 64'd1);
        bready = 1;
        #1;
        chk("awar_arready_resp", 64'(arready), 64'd0);
        @(posedge clock); #1;
        bready = 0;
        chk("awar_bvalid_drop", 64'(bvalid), 64'd0);
        chk("awar_arready_idle", 64'(arready), 64'd1);
        @(posedge clock); #1;
        arvalid = 0;
        exp_cmp = merge_model(exp_cmp, 64'h5A5A_0000_C3C3_0001, 8'hFF);
        chk("awar_rvalid", 64'(rvalid), 64'd1);
        chk("awar_rdata", rdata, exp_cmp);
        chk("awar_rresp", 64'(rresp), 64'd0);
        rready = 1;
        @(posedge clock); #1;
        rready = 0;
        $display("awar  write then read addr=%h data=%h", A_CMP, exp_cmp);

        // Random writes (legal mtimecmp, legal mtime, random addresses) with read-back.
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 3));
            data = {$urandom, $urandom};
            strb = 8'($urandom_range(0, 255));
            lead = int'($urandom_range(0, 6)) - 3;
            if (kind <= 1) addr = A_CMP;
            else if (kind == 2) addr = {32'd0, $urandom} | 64'(it % 2);
            else begin
                addr = A_MTIME;
                strb = 8'hFF;
            end
            w0 = wen_cnt;
            do_write(addr, data, strb, lead, int'($urandom_range(0, 2)), resp, wen_e, lat);
            chk("rnd_bresp", 64'(resp), 64'(resp_model(addr)));
            chk("rnd_wen_count", 64'(wen_cnt - w0), (resp_model(addr) == 2'b00) ? 64'd1 : 64'd0);
            chk("rnd_bvalid_lat", 64'(lat), 64'd2);
            if (addr == A_CMP) exp_cmp = merge_model(exp_cmp, data, strb);
            do_read(A_CMP, int'($urandom_range(0, 2)), d, resp, lat, acc);
            chk("rnd_cmp_rdata", d, exp_cmp);
            chk("rnd_cmp_rresp", 64'(resp), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
